// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 demultiplexer: one producer word is steered into one of eight
// single-word channel registers, each drained independently by a valid/ack handshake.
//
// channel state | meaning
// EMPTY         | valid_q[i]=0, channel accepts a write
// FULL          | valid_q[i]=1, word waiting for out_ack[i]; a write is accepted only
//               | together with out_ack[i], which reloads the channel
module demux_1to8_reg #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_sel,
  input  logic [W-1:0]   in_data,
  output logic [8*W-1:0] out_data,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ack,
  output logic [3:0]     occupancy
);

  logic [8*W-1:0] data_q, data_d;
  logic [7:0]     valid_q, valid_d;
  logic [3:0]     occ_q, occ_d;
  logic           wr_en;

  // in_ready looks only at the selected channel so a full channel blocks only itself.
  always_comb begin
    in_ready = ~valid_q[in_sel] | out_ack[in_sel];
    wr_en    = in_valid & in_ready;
    data_d   = data_q;
    valid_d  = valid_q;
    occ_d    = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (wr_en && (in_sel == 3'(i))) begin
        data_d[i*W +: W] = in_data;
        valid_d[i]       = 1'b1;
      end else if (out_ack[i]) begin
        valid_d[i]       = 1'b0;
      end
    end
    // Occupancy tracks the next valid vector so the registered count lines up with out_valid.
    for (int i = 0; i < 8; i++) begin
      occ_d = occ_d + 4'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Self-checking bench for demux_1to8_reg: directed vector table plus a randomized
// stream, both compared against a channel-level reference model.
module tb_demux_1to8_reg;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [8*W-1:0] out_data;
  logic [7:0]     out_valid;
  logic [7:0]     out_ack;
  logic [3:0]     occupancy;

  int checks = 0;
  int errors = 0;

  demux_1to8_reg #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: each channel is a one-word mailbox with a full flag.
  bit [7:0]     m_full;
  logic [W-1:0] m_word [8];
  bit           m_known = 1'b0;

  typedef struct {
    bit           rst;
    bit           iv;
    logic [2:0]   sel;
    logic [W-1:0] d;
    logic [7:0]   ack;
    bit           rdy;
    logic [7:0]   vld;
    logic [3:0]   occ;
    int           ch;
    logic [W-1:0] chd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input bit iv, input logic [2:0] sel,
                              input logic [W-1:0] d, input logic [7:0] ack, input bit rdy,
                              input logic [7:0] vld, input logic [3:0] occ, input int ch,
                              input logic [W-1:0] chd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sel = sel; v.d = d; v.ack = ack;
    v.rdy = rdy; v.vld = vld; v.occ = occ; v.ch = ch; v.chd = chd;
    tbl.push_back(v);
  endfunction

  // One clock: apply inputs, check in_ready, advance model, check registered outputs.
  task automatic run_cycle(input bit rst, input bit iv, input logic [2:0] sel,
                           input logic [W-1:0] d, input logic [7:0] ack, output bit rdy_seen);
    bit exp_rdy;
    bit accept;
    rst_n = rst; in_valid = iv; in_sel = sel; in_data = d; out_ack = ack;
    #1;
    rdy_seen = in_ready;
    exp_rdy  = !m_full[sel] || ack[sel];
    if (m_known) check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    accept = iv && exp_rdy;
    @(posedge clk);
    if (!rst) begin
      m_full = '0;
      for (int i = 0; i < 8; i++) m_word[i] = '0;
      m_known = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept && sel == 3'(i)) begin
          m_word[i] = d;
          m_full[i] = 1'b1;
        end else if (ack[i] && m_full[i]) begin
          m_full[i] = 1'b0;
        end
      end
    end
    #1;
    if (m_known) begin
      check("out_valid", {24'd0, out_valid}, {24'd0, m_full});
      check("occupancy", {28'd0, occupancy}, W'($countones(m_full)));
      for (int i = 0; i < 8; i++)
        check($sformatf("ch%0d_data", i), out_data[i*W +: W], m_word[i]);
    end
  endtask

  initial begin
    bit rdy;
    int r;

    // Reset with random inputs on the bus.
    for (int k = 0; k < 2; k++)
      run_cycle(1'b0, 1'($urandom), 3'($urandom), $urandom, 8'($urandom), rdy);

    add(1, 1, 3'd5, 32'hDEADBEEF, 8'h00, 1, 8'h20, 4'd1, 5, 32'hDEADBEEF);
    add(1, 1, 3'd5, 32'h11111111, 8'h00, 0, 8'h20, 4'd1, 5, 32'hDEADBEEF);
    add(1, 0, 3'd5, 32'h0,        8'h20, 1, 8'h00, 4'd0, 5, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++)
      add(1, 1, 3'(i), W'(i), 8'h00, 1, 8'((1 << (i + 1)) - 1), 4'(i + 1), i, W'(i));
    for (int i = 0; i < 8; i++)
      add(1, 1, 3'(i), 32'h77, 8'h00, 0, 8'hFF, 4'd8, i, W'(i));
    add(1, 1, 3'd3, 32'h55, 8'h08, 1, 8'hFF, 4'd8, 3, 32'h55);
    add(1, 0, 3'd1, 32'h0,  8'h02, 1, 8'hFD, 4'd7, 1, 32'h1);
    add(1, 1, 3'd1, 32'hAA, 8'h40, 1, 8'hBF, 4'd7, 1, 32'hAA);
    add(1, 0, 3'd6, 32'h0,  8'h40, 1, 8'hBF, 4'd7, 6, 32'h6);
    add(1, 0, 3'd0, 32'h0,  8'h01, 1, 8'hBE, 4'd6, 0, 32'h0);
    add(1, 0, 3'd0, 32'h0,  8'h01, 1, 8'hBE, 4'd6, 0, 32'h0);
    add(0, 1, 3'd2, 32'h99, 8'h04, 1, 8'h00, 4'd0, 2, 32'h0);

    foreach (tbl[n]) begin
      run_cycle(tbl[n].rst, tbl[n].iv, tbl[n].sel, tbl[n].d, tbl[n].ack, rdy);
      check($sformatf("vec%0d_ready", n), {31'd0, rdy}, {31'd0, tbl[n].rdy});
      check($sformatf("vec%0d_valid", n), {24'd0, out_valid}, {24'd0, tbl[n].vld});
      check($sformatf("vec%0d_occ", n), {28'd0, occupancy}, {28'd0, tbl[n].occ});
      check($sformatf("vec%0d_ch%0d", n, tbl[n].ch), out_data[tbl[n].ch*W +: W], tbl[n].chd);
    end

    // Hand sequence: write and ack on the same channel in consecutive cycles streams one word per cycle.
    run_cycle(1, 1, 3'd4, 32'hA0, 8'h00, rdy);
    for (int k = 1; k < 4; k++) begin
      run_cycle(1, 1, 3'd4, W'(32'hA0 + k), 8'h10, rdy);
      check("stream_ready", {31'd0, rdy}, 32'd1);
      check("stream_data", out_data[4*W +: W], W'(32'hA0 + k));
    end
    run_cycle(1, 0, 3'd4, 32'h0, 8'h10, rdy);

    // Randomized stream against the model.
    for (int k = 0; k < 100; k++) begin
      r = int'($urandom_range(0, 99));
      run_cycle(r >= 3, 1'($urandom), 3'($urandom), $urandom, 8'($urandom) & 8'($urandom), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
